// File: rtl/serial_adder.sv
// serial_adder: bit-serial unsigned adder, {cout,sum} = a + b + cin, LSB first.
// Latency: out_valid rises exactly WIDTH cycles after the accepting edge.
// Backpressure: one operation in flight; in_ready only in IDLE, DONE holds until out_ready.
//
// Ports:
//   clk, rst_n             clock (rising edge) and asynchronous active-low reset
//   in_valid / in_ready    operand handshake (a, b, cin sampled on acceptance)
//   out_valid / out_ready  result handshake (sum, cout registered and held)
//   busy                   high whenever the FSM is not in IDLE
//   ovf                    two's-complement overflow, present only when the
//                          macro SERIAL_ADDER_OVF_EN is defined
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);

  // Counter must reach WIDTH itself, so it needs clog2(WIDTH+1) bits.
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  // acc_q starts as operand A and shifts right; result bits enter at the MSB,
  // so after WIDTH shifts it holds the complete sum. The visible sum_q is only
  // written at completion, which keeps the previous result stable during RUN.
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q;
`endif

  // Full-adder cell on the current LSBs.
  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] b_d;
  logic [CW-1:0]    count_d;
  logic             last_bit;

  assign fa_s = acc_q[0] ^ b_q[0] ^ carry_q;
  assign fa_c = (acc_q[0] & b_q[0]) | (acc_q[0] & carry_q) | (b_q[0] & carry_q);

  // A one-bit accumulator has no upper bits to shift down.
  if (WIDTH == 1) begin : g_acc_w1
    assign acc_d = fa_s;
  end else begin : g_acc_wn
    assign acc_d = {fa_s, acc_q[WIDTH-1:1]};
  end

  assign b_d      = b_q >> 1;
  assign count_d  = count_q + CW'(1);
  assign last_bit = (count_d == CW'(WIDTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      count_q     <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            acc_q      <= a;
            b_q        <= b;
            carry_q    <= cin;
            count_q    <= '0;
            state_q    <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          acc_q   <= acc_d;
          b_q     <= b_d;
          carry_q <= fa_c;
          count_q <= count_d;
          if (last_bit) begin
            sum_q       <= acc_d;
            cout_q      <= fa_c;
`ifdef SERIAL_ADDER_OVF_EN
            // carry_q is still the carry into the MSB on this edge.
            ovf_q       <= carry_q ^ fa_c;
`endif
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_valid_q && out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed checks of serial_adder at WIDTH=8, exhaustive WIDTH=4,
// and all WIDTH=1 combinations. Inputs are driven and outputs sampled on the
// falling clock edge; the DUT acts on the rising edge.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8, busy8;
  logic [7:0] a8, b8, sum8;
  logic       in_valid4, in_ready4, cin4, out_valid4, out_ready4, cout4, busy4;
  logic [3:0] a4, b4, sum4;
  logic       in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1, busy1;
  logic [0:0] a1, b1, sum1;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf8, ovf4, ovf1;
`endif

  int checks   = 0;
  int failures = 0;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(ovf8),
`endif
    .busy(busy8)
  );

  serial_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .cout(cout4),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(ovf4),
`endif
    .busy(busy4)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(ovf1),
`endif
    .busy(busy1)
  );

  // Stimulus only: offers one operand set to the 8-bit DUT, then waits for
  // out_valid. Returns the number of edges from acceptance to out_valid and
  // whether busy/in_ready looked right during the run. Ends on the falling
  // edge where out_valid is first seen.
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                      output int lat, output bit run_ok);
    a8 = ta; b8 = tb_v; cin8 = tc; in_valid8 = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid8 = 1'b0;
    lat = -1;
    run_ok = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      if (busy8 !== 1'b1 || in_ready8 !== 1'b0) run_ok = 1'b0;
      @(posedge clk); @(negedge clk);
      if (out_valid8 === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid8 = 0; a8 = 0; b8 = 0; cin8 = 0; out_ready8 = 1;
    in_valid4 = 0; a4 = 0; b4 = 0; cin4 = 0; out_ready4 = 1;
    in_valid1 = 0; a1 = 0; b1 = 0; cin1 = 0; out_ready1 = 1;
    @(negedge clk); @(negedge clk);
    checks++;
    if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || busy8 !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: in_ready=%b out_valid=%b busy=%b, required 1 0 0",
               in_ready8, out_valid8, busy8);
    end
    checks++;
    if ({cout8, sum8} !== 9'h000) begin
      failures++;
      $display("FAIL reset_result: {cout,sum}=%h, required 000", {cout8, sum8});
    end
`ifdef SERIAL_ADDER_OVF_EN
    checks++;
    if (ovf8 !== 1'b0) begin
      failures++;
      $display("FAIL reset_ovf: ovf=%b, required 0", ovf8);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_carry_out;
    int lat; bit ok;
    out_ready8 = 1'b1;
    run8(8'hFF, 8'h01, 1'b0, lat, ok);
    checks++;
    if (lat !== 8) begin
      failures++;
      $display("FAIL carry_latency: latency=%0d, required 8", lat);
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL carry_run_flags: busy/in_ready wrong during RUN, required busy=1 in_ready=0");
    end
    checks++;
    if (sum8 !== 8'h00 || cout8 !== 1'b1) begin
      failures++;
      $display("FAIL carry_result: sum=%h cout=%b, required 00 1", sum8, cout8);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
      failures++;
      $display("FAIL carry_one_cycle_valid: out_valid=%b in_ready=%b, required 0 1",
               out_valid8, in_ready8);
    end
  endtask

  task automatic test_overflow;
    int lat; bit ok;
    out_ready8 = 1'b1;
    run8(8'h7F, 8'h01, 1'b0, lat, ok);
    checks++;
    if (sum8 !== 8'h80 || cout8 !== 1'b0 || lat !== 8) begin
      failures++;
      $display("FAIL ovf_7f_result: sum=%h cout=%b lat=%0d, required 80 0 8", sum8, cout8, lat);
    end
`ifdef SERIAL_ADDER_OVF_EN
    checks++;
    if (ovf8 !== 1'b1) begin
      failures++;
      $display("FAIL ovf_7f_flag: ovf=%b, required 1", ovf8);
    end
`endif
    @(posedge clk); @(negedge clk);
    run8(8'h80, 8'h80, 1'b0, lat, ok);
    checks++;
    if (sum8 !== 8'h00 || cout8 !== 1'b1 || lat !== 8) begin
      failures++;
      $display("FAIL ovf_80_result: sum=%h cout=%b lat=%0d, required 00 1 8", sum8, cout8, lat);
    end
`ifdef SERIAL_ADDER_OVF_EN
    checks++;
    if (ovf8 !== 1'b1) begin
      failures++;
      $display("FAIL ovf_80_flag: ovf=%b, required 1", ovf8);
    end
`endif
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_backpressure;
    int lat; bit ok;
    out_ready8 = 1'b0;
    run8(8'h12, 8'h34, 1'b0, lat, ok);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid8 !== 1'b1 || sum8 !== 8'h46 || cout8 !== 1'b0 || in_ready8 !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold_%0d: out_valid=%b sum=%h cout=%b in_ready=%b, required 1 46 0 0",
                 i, out_valid8, sum8, cout8, in_ready8);
      end
      @(posedge clk); @(negedge clk);
    end
    out_ready8 = 1'b1;
    checks++;
    if (out_valid8 !== 1'b1 || in_ready8 !== 1'b0) begin
      failures++;
      $display("FAIL bp_before_handshake: out_valid=%b in_ready=%b, required 1 0",
               out_valid8, in_ready8);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || sum8 !== 8'h46) begin
      failures++;
      $display("FAIL bp_after_handshake: in_ready=%b out_valid=%b sum=%h, required 1 0 46",
               in_ready8, out_valid8, sum8);
    end
  endtask

  task automatic test_ignore_in_valid;
    int lat;
    out_ready8 = 1'b1;
    a8 = 8'h21; b8 = 8'h13; cin8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid8 = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      if (k == 2) begin
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; in_valid8 = 1'b1;
      end
      if (k == 4) in_valid8 = 1'b0;
      @(posedge clk); @(negedge clk);
      if (out_valid8 === 1'b1) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (sum8 !== 8'h34 || cout8 !== 1'b0 || lat !== 8) begin
      failures++;
      $display("FAIL ignore_result: sum=%h cout=%b lat=%0d, required 34 0 8", sum8, cout8, lat);
    end
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    checks++;
    if (busy8 !== 1'b0 || in_ready8 !== 1'b1) begin
      failures++;
      $display("FAIL ignore_no_second_op: busy=%b in_ready=%b, required 0 1", busy8, in_ready8);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    out_ready8 = 1'b1;
    a8 = 8'h0F; b8 = 8'h0F; cin8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid8 = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    checks++;
    if (sum8 !== 8'h34 || cout8 !== 1'b0 || busy8 !== 1'b1) begin
      failures++;
      $display("FAIL retain_during_run: sum=%h cout=%b busy=%b, required 34 0 1", sum8, cout8, busy8);
    end
    lat = -1;
    for (int k = 3; k <= 40; k++) begin
      @(posedge clk); @(negedge clk);
      if (out_valid8 === 1'b1) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (sum8 !== 8'h1E || cout8 !== 1'b0 || lat !== 8) begin
      failures++;
      $display("FAIL b2b_result: sum=%h cout=%b lat=%0d, required 1e 0 8", sum8, cout8, lat);
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset_abort;
    int lat; bit ok;
    out_ready8 = 1'b1;
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; in_valid8 = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid8 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || busy8 !== 1'b0 || {cout8, sum8} !== 9'h000) begin
      failures++;
      $display("FAIL abort_immediate: in_ready=%b out_valid=%b busy=%b {cout,sum}=%h, required 1 0 0 000",
               in_ready8, out_valid8, busy8, {cout8, sum8});
    end
    @(negedge clk);
    checks++;
    if (out_valid8 !== 1'b0 || busy8 !== 1'b0) begin
      failures++;
      $display("FAIL abort_held: out_valid=%b busy=%b, required 0 0", out_valid8, busy8);
    end
    rst_n = 1'b1;
    @(negedge clk);
    run8(8'h05, 8'h03, 1'b1, lat, ok);
    checks++;
    if (sum8 !== 8'h09 || cout8 !== 1'b0 || lat !== 8 || !ok) begin
      failures++;
      $display("FAIL abort_next_op: sum=%h cout=%b lat=%0d flags_ok=%b, required 09 0 8 1",
               sum8, cout8, lat, ok);
    end
`ifdef SERIAL_ADDER_OVF_EN
    checks++;
    if (ovf8 !== 1'b0) begin
      failures++;
      $display("FAIL abort_next_ovf: ovf=%b, required 0", ovf8);
    end
`endif
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_exhaustive_w4;
    logic [3:0] ta, tb_v;
    logic       tc;
    logic [4:0] expv;
    logic       idle_ok;
    int         lat;
    out_ready4 = 1'b1;
    for (int i = 0; i < 512; i++) begin
      ta = i[3:0]; tb_v = i[7:4]; tc = i[8];
      expv = {1'b0, ta} + {1'b0, tb_v} + {4'b0, tc};
      idle_ok = (in_ready4 === 1'b1) && (busy4 === 1'b0);
      a4 = ta; b4 = tb_v; cin4 = tc; in_valid4 = 1'b1;
      @(posedge clk); @(negedge clk);
      in_valid4 = 1'b0;
      lat = -1;
      for (int k = 1; k <= 10; k++) begin
        @(posedge clk); @(negedge clk);
        if (out_valid4 === 1'b1) begin
          lat = k;
          break;
        end
      end
      checks++;
      if ({cout4, sum4} !== expv || lat !== 4 || !idle_ok) begin
        failures++;
        $display("FAIL w4_sum a=%h b=%h cin=%b: {cout,sum}=%h lat=%0d idle=%b, required %h 4 1",
                 ta, tb_v, tc, {cout4, sum4}, lat, idle_ok, expv);
      end
`ifdef SERIAL_ADDER_OVF_EN
      checks++;
      if (ovf4 !== ((ta[3] == tb_v[3]) && (expv[3] != ta[3]))) begin
        failures++;
        $display("FAIL w4_ovf a=%h b=%h cin=%b: ovf=%b", ta, tb_v, tc, ovf4);
      end
`endif
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic test_width1;
    logic [1:0] expv;
    logic       idle_ok;
    int         lat;
    out_ready1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      expv = {1'b0, i[0]} + {1'b0, i[1]} + {1'b0, i[2]};
      idle_ok = (in_ready1 === 1'b1) && (busy1 === 1'b0);
      a1 = i[0]; b1 = i[1]; cin1 = i[2]; in_valid1 = 1'b1;
      @(posedge clk); @(negedge clk);
      in_valid1 = 1'b0;
      lat = -1;
      for (int k = 1; k <= 6; k++) begin
        @(posedge clk); @(negedge clk);
        if (out_valid1 === 1'b1) begin
          lat = k;
          break;
        end
      end
      checks++;
      if ({cout1, sum1} !== expv || lat !== 1 || !idle_ok) begin
        failures++;
        $display("FAIL w1_sum combo=%0d: {cout,sum}=%b lat=%0d idle=%b, required %b 1 1",
                 i, {cout1, sum1}, lat, idle_ok, expv);
      end
      @(posedge clk); @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_carry_out();
    test_overflow();
    test_backpressure();
    test_ignore_in_valid();
    test_back_to_back();
    test_reset_abort();
    test_exhaustive_w4();
    test_width1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range is 1 to 32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the producer offers an operand set.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts operands this cycle.
REQ-006 The block SHALL have port a, input, WIDTH bits: addend A, unsigned.
REQ-007 The block SHALL have port b, input, WIDTH bits: addend B, unsigned.
REQ-008 The block SHALL have port cin, input, 1 bit: carry-in.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the result is available.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-011 The block SHALL have port sum, output, WIDTH bits: the result, registered.
REQ-012 The block SHALL have port cout, output, 1 bit: carry-out, registered.
REQ-013 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-014 The block SHALL add bit-serially, LSB first, processing one bit per clock through a single full-adder cell (s = a^b^c, c' = ab|ac|bc) and a carry flop.
REQ-015 The block SHALL implement an FSM with states IDLE, RUN and DONE; in_ready SHALL be 1 only in IDLE.
REQ-016 In IDLE, an edge with in_valid&in_ready SHALL load a and b into shift registers, set carry<=cin and count<=0, and move to RUN; in_valid without acceptance SHALL change no state.
REQ-017 Each RUN edge SHALL shift one result bit into the sum register from the MSB side, update carry, and increment count.
REQ-018 The RUN edge on which count reaches WIDTH SHALL complete the sum, load cout from the final carry, and move to DONE.
REQ-019 Latency: out_valid SHALL rise exactly WIDTH cycles after the accepting edge, and no sooner.
REQ-020 In DONE, out_valid SHALL be 1 and sum and cout SHALL be stable; the edge with out_valid&out_ready SHALL return to IDLE.
REQ-021 If out_ready is already high when DONE is entered, out_valid SHALL last exactly one cycle.
REQ-022 While out_ready is low, DONE SHALL hold indefinitely with sum and cout unchanged.
REQ-023 The block SHALL hold only one operation in flight; in_valid in RUN or DONE SHALL be ignored.
REQ-024 The result SHALL be {cout,sum} = a+b+cin, with sum modulo 2^WIDTH.
REQ-025 sum and cout SHALL retain the last result after the handshake until the next completion overwrites them.
REQ-026 WIDTH=1 SHALL work with one RUN cycle.
REQ-027 The count register SHALL be sized to hold WIDTH without wrap-around.

Reset
REQ-028 When rst_n=0, the block SHALL immediately force state IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, carry=0 and count=0, independent of clk.
REQ-029 A reset during RUN or DONE SHALL abort the operation with no result delivered; the first acceptance after reset release SHALL behave normally.

Configuration
REQ-030 With macro SERIAL_ADDER_OVF_EN defined, the block SHALL add output port ovf (1 bit, registered, reset 0), set at completion to (carry into MSB) XOR cout, i.e. two's-complement overflow, and held like sum.
REQ-031 Without SERIAL_ADDER_OVF_EN, the ovf port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 Bench SHALL drive WIDTH=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, out_valid rising 8 cycles after acceptance.
REQ-033 Bench SHALL drive a=0x7F, b=0x01, cin=0 with the macro defined -> sum=0x80, cout=0, ovf=1; with a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1.
REQ-034 Bench SHALL hold out_ready low for 5 cycles after DONE, then raise it -> out_valid stays high 5 cycles with sum stable, and in_ready returns the cycle after the handshake.
REQ-035 Bench SHALL pulse in_valid with different operands during RUN -> the pulse is ignored and the first result is delivered unchanged.
REQ-036 Bench SHALL assert rst_n low at RUN cycle 3 -> outputs reach reset values immediately; the next operation a=0x05, b=0x03, cin=1 -> sum=0x09, cout=0.
REQ-037 Bench SHALL run WIDTH=4 exhaustively over all 512 combinations of a, b and cin -> {cout,sum} equals a+b+cin every time.
